word_array_mem: RTL and testbench

//   Clocked, parametrised successor to the single 8-bit word cell.

---
 rtl/word_array_mem_if.sv | 26 ++
 rtl/word_array_mem.sv | 110 +++++++++++
 tb/tb_word_array_mem.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/word_array_mem_if.sv
// Access bus for word_array_mem: request signals from the master,
// read data, status and error strobes back from the array.
interface word_array_mem_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) ();
  logic              sel;
  logic              op;
  logic [ADDR_W-1:0] addr;
  logic [WIDTH-1:0]  in_bus;
  logic              clr;
  logic [WIDTH-1:0]  out_bus;
  logic              out_valid;
  logic              busy;
  logic              err;

  modport master (
    output sel, op, addr, in_bus, clr,
    input  out_bus, out_valid, busy, err
  );

  modport slave (
    input  sel, op, addr, in_bus, clr,
    output out_bus, out_valid, busy, err
  );
endinterface

// File: rtl/word_array_mem.sv
// DEPTH x WIDTH word array with registered reads, a one-word-per-cycle
// bulk clear and registered error/valid strobes.
module word_array_mem #(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input logic             clk,
  input logic             rst_n,
  word_array_mem_if.slave bus
);
  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [WIDTH-1:0]  out_bus_q, out_bus_d;
  logic              out_valid_q, out_valid_d;
  logic              err_q, err_d;
  logic              wr_en;
  logic              in_range;

  // Extra bit lets DEPTH itself be compared when DEPTH is a power of two.
  assign in_range = {1'b0, bus.addr} < DEPTH_X;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (bus.clr) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        if (ptr_q == LAST_PTR) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A clear request wins over a simultaneous access; the access only errs.
  always_comb begin
    wr_en       = 1'b0;
    err_d       = 1'b0;
    out_valid_d = 1'b0;
    out_bus_d   = out_bus_q;
    case (state_q)
      IDLE: begin
        if (bus.clr) begin
          err_d     = bus.sel;
          out_bus_d = '0;
        end else if (bus.sel) begin
          if (!in_range) begin
            err_d = 1'b1;
          end else if (bus.op) begin
            wr_en = 1'b1;
          end else begin
            out_valid_d = 1'b1;
            out_bus_d   = mem[bus.addr];
          end
        end
      end
      CLEAR:   err_d = bus.sel;
      default: err_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      out_bus_q   <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      out_bus_q   <= out_bus_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      if (state_q == CLEAR) begin
        mem[ptr_q] <= '0;
      end else if (wr_en) begin
        mem[bus.addr] <= bus.in_bus;
      end
    end
  end

  assign bus.out_bus   = out_bus_q;
  assign bus.out_valid = out_valid_q;
  assign bus.err       = err_q;
  assign bus.busy      = (state_q == CLEAR);
endmodule

// File: tb/tb_word_array_mem.sv
// Scoreboard bench for word_array_mem: a 16-word and a 12-word instance
// driven with directed vectors; a monitor matches every pulse to the queue.
module tb_word_array_mem;
  typedef enum {V_IDLE, V_WRITE, V_READ, V_CLEAR, V_CLEAR_SEL} vec_t;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         cycle;
  } sb_rec_t;

  logic    clk;
  logic    rst_n;
  int      cyc = 0;
  int      n_checks = 0;
  int      n_failures = 0;
  int      busy_cnt;
  sb_rec_t sb_a[$];
  sb_rec_t sb_b[$];

  word_array_mem_if #(.WIDTH(8), .ADDR_W(4)) bus_a ();
  word_array_mem_if #(.WIDTH(8), .ADDR_W(4)) bus_b ();

  word_array_mem #(.WIDTH(8), .DEPTH(16)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  word_array_mem #(.WIDTH(8), .DEPTH(12)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkPulse(input string tag, input bit have, input sb_rec_t rec,
                            input logic v, input logic e, input logic [7:0] data);
    if (!have) begin
      n_checks++;
      n_failures++;
      $display("[TB] FAIL %s unexpected_pulse: got valid=%0b err=%0b expected none",
               tag, v, e);
    end else begin
      checkOutput({tag, " overlap"}, 32'(v && e), 32'd0);
      checkOutput({tag, " pulse_is_err"}, 32'(e), 32'(rec.is_err));
      checkOutput({tag, " pulse_cycle"}, cyc, rec.cycle);
      if (!rec.is_err) checkOutput({tag, " read_data"}, 32'(data), 32'(rec.data));
    end
  endtask

  // Every out_valid or err strobe must match the oldest queued expectation.
  always @(negedge clk) begin : monitor
    sb_rec_t rec;
    bit      have;
    if (bus_a.out_valid || bus_a.err) begin
      have = sb_a.size() > 0;
      if (have) rec = sb_a.pop_front();
      checkPulse("A", have, rec, bus_a.out_valid, bus_a.err, bus_a.out_bus);
    end
    if (bus_b.out_valid || bus_b.err) begin
      have = sb_b.size() > 0;
      if (have) rec = sb_b.pop_front();
      checkPulse("B", have, rec, bus_b.out_valid, bus_b.err, bus_b.out_bus);
    end
  end

  task automatic driveIdle();
    bus_a.sel = 1'b0; bus_a.op = 1'b0; bus_a.addr = '0; bus_a.in_bus = '0; bus_a.clr = 1'b0;
    bus_b.sel = 1'b0; bus_b.op = 1'b0; bus_b.addr = '0; bus_b.in_bus = '0; bus_b.clr = 1'b0;
  endtask

  // One vector per cycle; any strobe it should cause is due one cycle later.
  task automatic applyStimulus(input bit to_b, input vec_t kind, input logic [3:0] a,
                               input logic [7:0] d, input bit exp_err);
    sb_rec_t rec;
    logic    s, o, c;
    @(negedge clk);
    driveIdle();
    s = (kind == V_WRITE) || (kind == V_READ) || (kind == V_CLEAR_SEL);
    o = (kind == V_WRITE);
    c = (kind == V_CLEAR) || (kind == V_CLEAR_SEL);
    if (to_b) begin
      bus_b.sel = s; bus_b.op = o; bus_b.addr = a; bus_b.in_bus = d; bus_b.clr = c;
    end else begin
      bus_a.sel = s; bus_a.op = o; bus_a.addr = a; bus_a.in_bus = d; bus_a.clr = c;
    end
    rec.cycle  = cyc + 1;
    rec.is_err = exp_err || (kind == V_CLEAR_SEL);
    rec.data   = d;
    if (rec.is_err || kind == V_READ) begin
      if (to_b) sb_b.push_back(rec);
      else      sb_a.push_back(rec);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    driveIdle();
    repeat (3) @(negedge clk);
    checkOutput("reset out_bus", 32'(bus_a.out_bus), 32'd0);
    checkOutput("reset out_valid", 32'(bus_a.out_valid), 32'd0);
    checkOutput("reset busy", 32'(bus_a.busy), 32'd0);
    checkOutput("reset err", 32'(bus_a.err), 32'd0);
    checkOutput("reset B out_bus", 32'(bus_b.out_bus), 32'd0);
    rst_n = 1'b1;

    $display("[TB] reads after reset");
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, V_READ, 4'(i), 8'h00, 1'b0);

    $display("[TB] write/read and hold");
    applyStimulus(1'b0, V_WRITE, 4'd3, 8'h55, 1'b0);
    applyStimulus(1'b0, V_READ, 4'd3, 8'h55, 1'b0);
    applyStimulus(1'b0, V_IDLE, 4'd0, 8'h00, 1'b0);
    applyStimulus(1'b0, V_IDLE, 4'd0, 8'h00, 1'b0);
    checkOutput("hold out_bus", 32'(bus_a.out_bus), 32'h55);
    checkOutput("hold out_valid", 32'(bus_a.out_valid), 32'd0);

    $display("[TB] back-to-back write then read");
    applyStimulus(1'b0, V_WRITE, 4'd15, 8'hCC, 1'b0);
    applyStimulus(1'b0, V_READ, 4'd15, 8'hCC, 1'b0);
    applyStimulus(1'b0, V_READ, 4'd3, 8'h55, 1'b0);

    $display("[TB] bulk clear with simultaneous access");
    applyStimulus(1'b0, V_CLEAR_SEL, 4'd3, 8'h00, 1'b1);
    busy_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      if (i == 0)      applyStimulus(1'b0, V_READ, 4'd0, 8'h00, 1'b1);
      else if (i == 5) applyStimulus(1'b0, V_CLEAR, 4'd0, 8'h00, 1'b0);
      else             applyStimulus(1'b0, V_IDLE, 4'd0, 8'h00, 1'b0);
      if (bus_a.busy) busy_cnt++;
    end
    checkOutput("busy cycles", busy_cnt, 16);
    checkOutput("clear out_bus", 32'(bus_a.out_bus), 32'd0);
    applyStimulus(1'b0, V_READ, 4'd3, 8'h00, 1'b0);
    applyStimulus(1'b0, V_READ, 4'd15, 8'h00, 1'b0);

    $display("[TB] out-of-range accesses on 12-word array");
    applyStimulus(1'b1, V_WRITE, 4'd1, 8'h3C, 1'b0);
    applyStimulus(1'b1, V_WRITE, 4'd11, 8'hE1, 1'b0);
    applyStimulus(1'b1, V_WRITE, 4'd13, 8'h77, 1'b1);
    applyStimulus(1'b1, V_READ, 4'd11, 8'hE1, 1'b0);
    applyStimulus(1'b1, V_READ, 4'd0, 8'h00, 1'b0);
    applyStimulus(1'b1, V_READ, 4'd1, 8'h3C, 1'b0);
    applyStimulus(1'b1, V_READ, 4'd13, 8'h00, 1'b1);
    applyStimulus(1'b1, V_READ, 4'd12, 8'h00, 1'b1);
    applyStimulus(1'b1, V_IDLE, 4'd0, 8'h00, 1'b0);
    checkOutput("B held out_bus", 32'(bus_b.out_bus), 32'h3C);
    checkOutput("B out_valid after err", 32'(bus_b.out_valid), 32'd0);

    $display("[TB] reset in the middle of a clear");
    applyStimulus(1'b0, V_WRITE, 4'd14, 8'h9A, 1'b0);
    applyStimulus(1'b0, V_WRITE, 4'd3, 8'h11, 1'b0);
    applyStimulus(1'b0, V_READ, 4'd3, 8'h11, 1'b0);
    applyStimulus(1'b0, V_CLEAR, 4'd0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, V_IDLE, 4'd0, 8'h00, 1'b0);
    checkOutput("busy before reset", 32'(bus_a.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset busy", 32'(bus_a.busy), 32'd0);
    checkOutput("async reset out_bus", 32'(bus_a.out_bus), 32'd0);
    checkOutput("async reset err", 32'(bus_a.err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, V_READ, 4'd14, 8'h00, 1'b0);
    applyStimulus(1'b0, V_WRITE, 4'd7, 8'hA5, 1'b0);
    applyStimulus(1'b0, V_READ, 4'd7, 8'hA5, 1'b0);
    applyStimulus(1'b0, V_IDLE, 4'd0, 8'h00, 1'b0);
    checkOutput("post reset busy", 32'(bus_a.busy), 32'd0);

    repeat (3) applyStimulus(1'b0, V_IDLE, 4'd0, 8'h00, 1'b0);
    checkOutput("A responses outstanding", sb_a.size(), 32'd0);
    checkOutput("B responses outstanding", sb_b.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end
endmodule
